// File: rtl/sp_link_ctrl.sv
// sp_link_ctrl
//   Word-level link controller that sits behind the serial-to-parallel
//   converter and runs on the clk_4f word clock. It hunts for the COMMA
//   symbol, confirms LOCK_CNT consecutive commas before declaring lock,
//   forwards non-comma data words while locked (commas are idle and get
//   stripped), asks the converter for a bit slip while unaligned, and drops
//   lock after LOSS_CNT consecutive invalid words.
//
//   Handshake: data_in is consumed on every posedge where valid_in=1; there
//   is no backpressure. data_out is meaningful only on cycles where
//   valid_out=1, and it appears one edge after the matching input word.
//
// Ports
//   clk_4f     in   word clock, all logic on posedge
//   reset      in   asynchronous active-low reset
//   data_in    in   [7:0] parallel word from the converter
//   valid_in   in   data_in holds a valid word this cycle
//   data_out   out  [7:0] forwarded data word (holds when not updated)
//   valid_out  out  data_out valid (locked, non-comma word)
//   active     out  link locked
//   slip_req   out  one-cycle pulse asking for a one-bit boundary shift
//   loss_cnt   out  [7:0] lock losses since reset, saturating at 8'hFF
//   dbg_state  out  [1:0] current FSM state (0=HUNT, 1=CONFIRM, 2=LOCKED)
module sp_link_ctrl #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter int         LOCK_CNT  = 4,
  parameter int         LOSS_CNT  = 3,
  parameter int         SLIP_WAIT = 8
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       slip_req,
  output logic [7:0] loss_cnt,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(SLIP_WAIT);

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] LOSS_LAST  = BW'(LOSS_CNT - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [BW-1:0] bad, bad_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;
  logic          active_nxt;
  logic          slip_nxt;
  logic [7:0]    loss_nxt;
  logic          is_comma;

  assign is_comma  = (data_in == COMMA);
  assign dbg_state = state;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      cnt       <= '0;
      timer     <= '0;
      bad       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      slip_req  <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      bad       <= bad_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
      slip_req  <= slip_nxt;
      loss_cnt  <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    timer_nxt  = timer;
    bad_nxt    = bad;
    data_nxt   = data_out;
    valid_nxt  = 1'b0;
    active_nxt = active;
    slip_nxt   = 1'b0;
    loss_nxt   = loss_cnt;

    case (state)
      HUNT: begin
        if (valid_in) begin
          if (is_comma) begin
            // A comma always beats a slip that would fire on the same edge.
            timer_nxt = '0;
            if (LOCK_CNT == 1) begin
              state_nxt  = LOCKED;
              active_nxt = 1'b1;
              cnt_nxt    = '0;
              bad_nxt    = '0;
            end else begin
              state_nxt = CONFIRM;
              cnt_nxt   = CW'(1);
            end
          end else if (timer == TIMER_LAST) begin
            slip_nxt  = 1'b1;
            timer_nxt = '0;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
      end

      CONFIRM: begin
        if (valid_in) begin
          if (is_comma) begin
            if (cnt == LOCK_LAST) begin
              state_nxt  = LOCKED;
              active_nxt = 1'b1;
              cnt_nxt    = '0;
              bad_nxt    = '0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
            timer_nxt = '0;
          end
        end
      end

      LOCKED: begin
        if (valid_in) begin
          bad_nxt = '0;
          if (!is_comma) begin
            data_nxt  = data_in;
            valid_nxt = 1'b1;
          end
        end else if (bad == LOSS_LAST) begin
          state_nxt  = HUNT;
          active_nxt = 1'b0;
          cnt_nxt    = '0;
          timer_nxt  = '0;
          bad_nxt    = '0;
          loss_nxt   = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
        end else begin
          bad_nxt = bad + 1'b1;
        end
      end

      default: begin
        state_nxt  = HUNT;
        cnt_nxt    = '0;
        timer_nxt  = '0;
        bad_nxt    = '0;
        active_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sp_link_ctrl.sv
// tb_sp_link_ctrl
//   Self-checking bench for sp_link_ctrl. Inputs change on the falling edge;
//   outputs are sampled 1 time unit after the rising edge and compared with
//   a word-level reference model of the link behaviour.
module tb_sp_link_ctrl;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam int         LOCK_CNT  = 4;
  localparam int         LOSS_CNT  = 3;
  localparam int         SLIP_WAIT = 8;

  logic       clk_4f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       slip_req;
  logic [7:0] loss_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: link-level quantities, not an FSM encoding.
  bit         m_locked;
  int         m_commas;   // consecutive commas seen while unlocked
  int         m_noncomma; // non-comma words in a row since last slip/comma
  int         m_misses;   // consecutive invalid words while locked
  int         m_losses;
  logic [7:0] exp_data;
  bit         exp_valid;
  bit         exp_slip;

  sp_link_ctrl #(
    .COMMA(COMMA), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .slip_req (slip_req),
    .loss_cnt (loss_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic model_reset();
    m_locked   = 0;
    m_commas   = 0;
    m_noncomma = 0;
    m_misses   = 0;
    m_losses   = 0;
    exp_data   = 8'h00;
    exp_valid  = 0;
    exp_slip   = 0;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk_4f);
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (cycles) @(negedge clk_4f);
    reset = 1'b1;
    model_reset();
  endtask

  // Word-level behaviour of the link for one clock edge.
  task automatic model_step(input logic [7:0] d, input bit v);
    exp_valid = 0;
    exp_slip  = 0;
    if (!m_locked) begin
      if (v) begin
        if (d == COMMA) begin
          m_commas++;
          m_noncomma = 0;
          if (m_commas >= LOCK_CNT) begin
            m_locked = 1;
            m_misses = 0;
            m_commas = 0;
          end
        end else if (m_commas > 0) begin
          m_commas = 0; // alignment attempt aborted
        end else begin
          m_noncomma++;
          if (m_noncomma == SLIP_WAIT) begin
            exp_slip   = 1;
            m_noncomma = 0;
          end
        end
      end
    end else begin
      if (v) begin
        m_misses = 0;
        if (d != COMMA) begin
          exp_valid = 1;
          exp_data  = d;
        end
      end else begin
        m_misses++;
        if (m_misses == LOSS_CNT) begin
          m_locked   = 0;
          m_losses   = (m_losses < 255) ? m_losses + 1 : 255;
          m_commas   = 0;
          m_noncomma = 0;
          m_misses   = 0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [7:0] d, input bit v);
    @(negedge clk_4f);
    data_in  = d;
    valid_in = v;
    @(posedge clk_4f);
    #1;
    model_step(d, v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk_4f);
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk_4f);
    n_checks++;
    if ({data_out, valid_out, active, slip_req, loss_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%h required 0", {data_out, valid_out, active, slip_req, loss_cnt});
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      drive(8'h00, 0);
      n_checks++;
      if ({data_out, valid_out, active, slip_req, loss_cnt} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: outputs=%h required 0", i, {data_out, valid_out, active, slip_req, loss_cnt});
      end
    end
  endtask

  task automatic test_lock_and_forward();
    apply_reset(2);
    for (int i = 1; i <= 5; i++) begin
      drive(COMMA, 1);
      n_checks++;
      if (active !== (i >= 4)) begin
        n_fail++;
        $display("FAIL lock comma %0d: active=%b required %b", i, active, (i >= 4));
      end
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL lock comma %0d valid_out: got %b required 0", i, valid_out);
      end
    end
    drive(8'h5A, 1);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL forward_5a: valid_out=%b data_out=%h required 1/5a", valid_out, data_out);
    end
    drive(COMMA, 1);
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h5A || active !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_strip: valid_out=%b data_out=%h active=%b required 0/5a/1", valid_out, data_out, active);
    end
  endtask

  task automatic test_slip();
    int pulses;
    apply_reset(2);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(8'h17, 1);
      if (slip_req === 1'b1) pulses++;
      n_checks++;
      if (slip_req !== ((i % 8) == 0)) begin
        n_fail++;
        $display("FAIL slip word %0d: slip_req=%b required %b", i, slip_req, ((i % 8) == 0));
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL slip_count: got %0d required 2", pulses);
    end
    // Seven non-commas then a comma on the edge that would slip: no slip.
    for (int i = 0; i < 7; i++) drive(8'h17, 1);
    drive(COMMA, 1);
    n_checks++;
    if (slip_req !== 1'b0) begin
      n_fail++;
      $display("FAIL slip_vs_comma: slip_req=%b required 0", slip_req);
    end
  endtask

  task automatic test_loss();
    logic [7:0] d_seq[7];
    bit         v_seq[7];
    bit         a_exp[7];
    d_seq = '{8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
    v_seq = '{0, 0, 1, 0, 0, 0, 0};
    a_exp = '{1, 1, 1, 1, 1, 0, 0};
    apply_reset(2);
    for (int i = 0; i < LOCK_CNT; i++) drive(COMMA, 1);
    for (int i = 0; i < 7; i++) begin
      drive(d_seq[i], v_seq[i]);
      n_checks++;
      if (active !== a_exp[i]) begin
        n_fail++;
        $display("FAIL loss step %0d: active=%b required %b", i, active, a_exp[i]);
      end
    end
    n_checks++;
    if (loss_cnt !== 8'd1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_cnt: loss_cnt=%0d valid_out=%b required 1/0", loss_cnt, valid_out);
    end
  endtask

  task automatic test_abort();
    logic [7:0] seq[4];
    seq = '{COMMA, COMMA, 8'h33, COMMA};
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1);
      n_checks++;
      if (active !== 1'b0 || valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL abort step %0d: active=%b valid_out=%b required 0/0", i, active, valid_out);
      end
    end
    // After the abort only one comma has been seen: three more lock, two do not.
    drive(COMMA, 1);
    drive(COMMA, 1);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recount: active=%b required 0", active);
    end
    drive(COMMA, 1);
    n_checks++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_relock: active=%b required 1", active);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(2);
    for (int i = 0; i < LOCK_CNT; i++) drive(COMMA, 1);
    drive(8'h00, 0);
    drive(8'h00, 0);
    drive(8'h00, 0); // one loss so loss_cnt is non-zero
    for (int i = 0; i < LOCK_CNT; i++) drive(COMMA, 1);
    drive(8'hA7, 1);
    n_checks++;
    if (active !== 1'b1 || valid_out !== 1'b1 || loss_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL async_pre: active=%b valid_out=%b loss_cnt=%0d required 1/1/1", active, valid_out, loss_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (active !== 1'b0 || valid_out !== 1'b0 || loss_cnt !== 8'd0 || data_out !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: active=%b valid_out=%b loss_cnt=%0d data_out=%h required all 0",
               active, valid_out, loss_cnt, data_out);
    end
    @(negedge clk_4f);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_loss_saturation();
    apply_reset(2);
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < LOCK_CNT; i++) drive(COMMA, 1);
      for (int i = 0; i < LOSS_CNT; i++) drive(8'h00, 0);
    end
    n_checks++;
    if (loss_cnt !== 8'hFF || active !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_saturate: loss_cnt=%0d active=%b required 255/0", loss_cnt, active);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         v;
    apply_reset(2);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 3))
        0, 1:    d = COMMA;
        2:       d = 8'($urandom_range(0, 255));
        default: d = 8'h17;
      endcase
      drive(d, v);
      n_checks++;
      if (active !== m_locked || valid_out !== exp_valid || slip_req !== exp_slip ||
          data_out !== exp_data || loss_cnt !== 8'(m_losses)) begin
        n_fail++;
        $display("FAIL random cyc %0d: act=%b vo=%b slip=%b do=%h loss=%0d required act=%b vo=%b slip=%b do=%h loss=%0d",
                 i, active, valid_out, slip_req, data_out, loss_cnt,
                 m_locked, exp_valid, exp_slip, exp_data, m_losses);
      end
      n_checks++;
      if (valid_out === 1'b1 && active !== 1'b1) begin
        n_fail++;
        $display("FAIL random_valid_unlocked cyc %0d: valid_out=%b active=%b required active=1", i, valid_out, active);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();
    test_reset();
    test_lock_and_forward();
    test_slip();
    test_loss();
    test_abort();
    test_async_reset();
    test_loss_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
